// File: rtl/vram_arbiter.sv
// Arbitrates the single-port text VRAM between the Avalon-MM slave path and the
// renderer glyph-fetch path, with renderer priority bounded by a starvation counter.
module vram_arbiter #(
  parameter int unsigned DEPTH      = 2400,
  parameter int unsigned AW         = 12,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          AVL_CS,
  input  logic          AVL_READ,
  input  logic          AVL_WRITE,
  input  logic [3:0]    AVL_BYTE_EN,
  input  logic [AW-1:0] AVL_ADDR,
  input  logic [31:0]   AVL_WRITEDATA,
  output logic [31:0]   AVL_READDATA,
  output logic          AVL_WAITREQUEST,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic          rd_valid,
  output logic [31:0]   rd_data,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [3:0]    ram_be,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [AW-1:0] DEPTH_A    = AW'(DEPTH);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] AVL_RDATA = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic          avl_req, avl_gnt, avl_wr_gnt, avl_rd_gnt, rd_win;
  logic [AW-1:0] addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q, readdata_q, avl_rdata_c;
  logic          avl_oor_q, rd_pend_q, rd_oor_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Arbitration, starvation counting and next state; requests are masked in reset.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    avl_req    = ~Reset & AVL_CS & (AVL_READ | AVL_WRITE) & (state == IDLE);
    avl_gnt    = avl_req & (~rd_req | (starve_cnt == STARVE_TOP));
    avl_wr_gnt = avl_gnt & AVL_WRITE;
    avl_rd_gnt = avl_gnt & ~AVL_WRITE;
    rd_win     = ~Reset & rd_req & ~avl_gnt;
    if (!avl_req || avl_gnt)          starve_nxt = '0;
    else if (starve_cnt != STARVE_TOP) starve_nxt = starve_cnt + SW'(1);
    case (state)
      IDLE:      if (avl_rd_gnt) state_nxt = AVL_RDATA;
      AVL_RDATA: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      starve_cnt <= '0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      readdata_q <= '0;
      avl_oor_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_oor_q   <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      addr_q     <= ram_addr;
      if (avl_wr_gnt) begin
        be_q    <= AVL_BYTE_EN;
        wdata_q <= AVL_WRITEDATA;
      end
      avl_oor_q <= avl_rd_gnt & (AVL_ADDR >= DEPTH_A);
      rd_pend_q <= rd_win;
      rd_oor_q  <= rd_addr >= DEPTH_A;
      if (state == AVL_RDATA) readdata_q <= avl_rdata_c;
    end
  end

  // RAM port is driven in the grant cycle; address holds when nothing is granted.
  always_comb begin
    ram_addr  = avl_gnt ? AVL_ADDR : (rd_win ? rd_addr : addr_q);
    ram_we    = avl_wr_gnt & (AVL_ADDR < DEPTH_A);
    ram_be    = avl_wr_gnt ? AVL_BYTE_EN : be_q;
    ram_wdata = avl_wr_gnt ? AVL_WRITEDATA : wdata_q;
  end

  always_comb begin
    avl_rdata_c     = avl_oor_q ? 32'h0 : ram_rdata;
    AVL_READDATA    = (state == AVL_RDATA) ? avl_rdata_c : readdata_q;
    AVL_WAITREQUEST = Reset | (avl_req & ~avl_wr_gnt);
    rd_gnt          = rd_win;
    rd_valid        = rd_pend_q;
    rd_data         = (rd_pend_q && !rd_oor_q) ? ram_rdata : 32'h0;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port, 32-bit text VRAM between two requesters: the Avalon-MM slave path (CPU writes and reads of symbol words) and the renderer's glyph-fetch path.
- Holds 80 cols × 60 rows at 2 symbols per word, giving 2400 words.
- Issues at most one RAM access per cycle. The renderer normally has priority; a starvation counter guarantees the CPU forward progress.
- Sits between the Avalon interface / renderer and the VRAM instance inside the rendering top level.

Parameters:
- DEPTH, 2400, number of valid VRAM words; addresses >= DEPTH are out of range.
- AW, 12, address width.
- STARVE_MAX, 4, consecutive denied cycles after which an Avalon request wins arbitration.

Ports:
- Clk  in  1  system clock; all logic is on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- AVL_CS  in  1  Avalon chip select.
- AVL_READ  in  1  Avalon read strobe.
- AVL_WRITE  in  1  Avalon write strobe.
- AVL_BYTE_EN  in  4  Avalon byte enables.
- AVL_ADDR  in  AW  Avalon word address.
- AVL_WRITEDATA  in  32  Avalon write data.
- AVL_READDATA  out  32  Avalon read data; valid when a read completes.
- AVL_WAITREQUEST  out  1  stalls the Avalon master.
- rd_req  in  1  renderer fetch request; held until rd_gnt.
- rd_addr  in  AW  renderer word address.
- rd_gnt  out  1  renderer request accepted this cycle.
- rd_valid  out  1  rd_data valid (one-cycle pulse).
- rd_data  out  32  renderer fetch data.
- ram_addr  out  AW  VRAM address.
- ram_we  out  1  VRAM write enable.
- ram_be  out  4  VRAM byte enables.
- ram_wdata  out  32  VRAM write data.
- ram_rdata  in  32  VRAM read data; 1-cycle synchronous read latency.

Behaviour:
- Request definitions:
  - avl_req = AVL_CS & (AVL_READ | AVL_WRITE) while state ≠ AVL_RDATA.
  - If AVL_READ and AVL_WRITE are both high, the access is treated as a write.
- States:
  - IDLE: no Avalon read outstanding.
  - AVL_RDATA: Avalon read data returning this cycle.
  - Transitions: IDLE→AVL_RDATA on an Avalon read grant. AVL_RDATA→IDLE unconditionally.
- Arbitration, each cycle, combinational:
  - Avalon wins if avl_req & (~rd_req | starve_cnt == STARVE_MAX).
  - Otherwise the renderer wins if rd_req.
  - Otherwise no access: ram_we = 0, ram_addr holds its last value.
- In AVL_RDATA, only the renderer may be granted; the RAM port is pipelined, so a renderer issue overlaps the Avalon data return.
- Avalon write grant:
  - Drives ram_we = 1, ram_be = AVL_BYTE_EN, ram_addr = AVL_ADDR, ram_wdata = AVL_WRITEDATA.
  - AVL_WAITREQUEST = 0 in the grant cycle; the write completes that cycle.
- Avalon read grant:
  - Drives ram_addr = AVL_ADDR, ram_we = 0. AVL_WAITREQUEST = 1 in the grant cycle.
  - Next cycle (AVL_RDATA): AVL_READDATA is loaded from ram_rdata and AVL_WAITREQUEST = 0.
  - Minimum read latency is 2 cycles from request.
- AVL_WAITREQUEST = avl_req & ~(write granted). It is 0 when there is no request, and 0 in AVL_RDATA.
- Renderer grant:
  - rd_gnt = 1 and ram_addr = rd_addr.
  - rd_valid = 1 the next cycle with rd_data = ram_rdata.
  - Back-to-back renderer grants give one word per cycle.
- Out-of-range addresses (addr >= DEPTH):
  - Writes: ram_we is forced 0, but the Avalon handshake still completes.
  - Reads: return 0 on AVL_READDATA or rd_data, with the normal timing.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) each cycle avl_req = 1 and Avalon is not granted.
  - Clears on an Avalon grant or when avl_req = 0.
- AVL_READDATA holds its value until the next completed read.
- Reset (asynchronous, any time, including mid-read):
  - state = IDLE, starve_cnt = 0, rd_valid = 0, rd_data = 0, AVL_READDATA = 0, ram_we = 0, ram_addr = 0, ram_be = 0, ram_wdata = 0, rd_gnt = 0.
  - AVL_WAITREQUEST = 1 while Reset is high.
  - A read in flight at reset is abandoned; it does not complete after reset.

Test Plan:
- Avalon write then read, no renderer traffic: write 0xDEADBEEF to addr 5 with BYTE_EN = 4'hF, then read addr 5 → write waitrequest 0 in cycle 0; read waitrequest high 1 cycle; READDATA = 0xDEADBEEF in cycle 2.
- Byte-enable write: write 0x11223344 with BYTE_EN = 4'b0101 over 0xFFFFFFFF → readback 0xFF22FF44.
- Renderer streaming: rd_req held with addresses 0..9 → rd_gnt every cycle; rd_valid each cycle with data matching preloaded RAM, 1-cycle lag.
- Starvation: rd_req held continuously while the Avalon master writes addr 7 → waitrequest high for exactly 4 cycles; write granted on the 5th; rd_gnt = 0 that cycle only.
- Out-of-range: write to addr 2400 → handshake completes, ram_we stays 0; read of addr 4000 → READDATA = 0.
- Reset during AVL_RDATA: assert Reset asynchronously mid-read → AVL_WAITREQUEST = 1 and all outputs 0 immediately; after release, state IDLE and no stray rd_valid or read completion.
